// File: rtl/vga_pkg.sv
// Shared VGA/screen types and default frame limits for the game display path.
package vga_pkg;

  typedef enum logic [1:0] {
    SCR_START  = 2'd0,
    SCR_PLAY   = 2'd1,
    SCR_FINISH = 2'd2
  } screen_t;

  localparam int MIN_FINISH_FRAMES_DEF     = 60;
  localparam int FINISH_TIMEOUT_FRAMES_DEF = 600;

  localparam int HW    = 11;
  localparam int VW    = 11;
  localparam int RGB_W = 12;

  typedef struct packed {
    logic [VW-1:0]    vcount;
    logic             vsync;
    logic             vblnk;
    logic [HW-1:0]    hcount;
    logic             hsync;
    logic             hblnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

endpackage

// File: rtl/vga_if.sv
// One VGA stream: timing fields plus pixel colour.
interface vga_if;
  import vga_pkg::*;

  logic [VW-1:0]    vcount;
  logic             vsync;
  logic             vblnk;
  logic [HW-1:0]    hcount;
  logic             hsync;
  logic             hblnk;
  logic [RGB_W-1:0] rgb;

  modport in (
    input vcount, vsync, vblnk,
    input hcount, hsync, hblnk,
    input rgb
  );

  modport out (
    output vcount, vsync, vblnk,
    output hcount, hsync, hblnk,
    output rgb
  );
endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus a registered rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= btn;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/screen_ctrl.sv
// START/PLAY/FINISH screen sequencer and frame-aligned VGA source mux.
// Optional FINISH auto-return: define SCREEN_CTRL_TIMEOUT_EN.
module screen_ctrl
  import vga_pkg::*;
#(
  parameter int MIN_FINISH_FRAMES     = MIN_FINISH_FRAMES_DEF,
  parameter int FINISH_TIMEOUT_FRAMES = FINISH_TIMEOUT_FRAMES_DEF,
  parameter int CNT_W                 = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       game_over,
  vga_if.in          vga_start,
  vga_if.in          vga_game,
  vga_if.in          vga_finish,
  vga_if.out         vga_out,
  output logic [1:0] screen,
  output logic       game_active,
  output logic       game_rst
);

  if ((2**CNT_W) <= MIN_FINISH_FRAMES ||
      (2**CNT_W) <= FINISH_TIMEOUT_FRAMES) begin : g_cnt_w_check
    $error("CNT_W too small for frame limits");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_FINISH_FRAMES);

  logic                btn_edge;
  screen_t             state;
  logic                pend_valid;
  screen_t             pend_target;
  logic [CNT_W-1:0]    frame_cnt;
  logic                vblnk_d;
  logic                fb;
  logic                commit;
  logic                legal;
  logic                timeout_req;
  logic                req_valid;
  screen_t             req_target;
  vga_t                src;
  vga_t                out_q;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start),
    .pulse (btn_edge)
  );

  assign fb     = vga_start.vblnk & ~vblnk_d;
  assign commit = fb & pend_valid;
  assign legal  = (state == SCR_START) ||
                  (state == SCR_PLAY)  ||
                  (state == SCR_FINISH);

`ifdef SCREEN_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(FINISH_TIMEOUT_FRAMES);
  assign timeout_req = (state == SCR_FINISH) && (frame_cnt >= TO_CNT);
`else
  assign timeout_req = 1'b0;
`endif

  always_comb begin
    req_valid  = 1'b0;
    req_target = SCR_START;
    case (state)
      SCR_START: begin
        if (btn_edge) begin
          req_valid  = 1'b1;
          req_target = SCR_PLAY;
        end
      end
      SCR_PLAY: begin
        if (game_over) begin
          req_valid  = 1'b1;
          req_target = SCR_FINISH;
        end
      end
      SCR_FINISH: begin
        // an early press is dropped, not held until the lockout expires
        if ((btn_edge && frame_cnt >= MIN_CNT) || timeout_req) begin
          req_valid  = 1'b1;
          req_target = SCR_START;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCR_START;
      pend_valid  <= 1'b0;
      pend_target <= SCR_START;
      frame_cnt   <= '0;
      vblnk_d     <= 1'b0;
    end else begin
      vblnk_d <= vga_start.vblnk;
      if (!legal) begin
        state      <= SCR_START;
        pend_valid <= 1'b0;
      end else if (commit) begin
        state      <= pend_target;
        pend_valid <= 1'b0;
      end else if (!pend_valid && req_valid) begin
        pend_valid  <= 1'b1;
        pend_target <= req_target;
      end
      if (commit && pend_target == SCR_FINISH)
        frame_cnt <= '0;
      else if (state == SCR_FINISH && fb && frame_cnt != CNT_MAX)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign screen      = state;
  assign game_active = (state == SCR_PLAY);
  assign game_rst    = commit && (pend_target == SCR_PLAY);

  always_comb begin
    case (state)
      SCR_PLAY: src = '{vga_game.vcount, vga_game.vsync,
                        vga_game.vblnk, vga_game.hcount,
                        vga_game.hsync, vga_game.hblnk,
                        vga_game.rgb};
      SCR_FINISH: src = '{vga_finish.vcount, vga_finish.vsync,
                          vga_finish.vblnk, vga_finish.hcount,
                          vga_finish.hsync, vga_finish.hblnk,
                          vga_finish.rgb};
      default: src = '{vga_start.vcount, vga_start.vsync,
                       vga_start.vblnk, vga_start.hcount,
                       vga_start.hsync, vga_start.hblnk,
                       vga_start.rgb};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= src;
  end

  assign vga_out.vcount = out_q.vcount;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.hcount = out_q.hcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed bench for screen_ctrl on a tiny 8x6 frame (4 active lines).
module tb_screen_ctrl;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0;
  logic game_over = 1'b0;
  logic [1:0] screen;
  logic game_active;
  logic game_rst;

  int n_cmp = 0;
  int n_err = 0;
  int grst_cnt = 0;
  int g0;
  logic [11:0] erg;
  logic [37:0] exp_bus;

  always #5 clk = ~clk;

  logic [10:0] hc = '0;
  logic [10:0] vc = '0;

  always @(posedge clk) begin
    if (hc == 11'd7) begin
      hc <= '0;
      vc <= (vc == 11'd5) ? 11'd0 : vc + 11'd1;
    end else begin
      hc <= hc + 11'd1;
    end
  end

  vga_if vs();
  vga_if vg();
  vga_if vf();
  vga_if vo();

  assign vs.vcount = vc;
  assign vs.vsync  = (vc == 11'd5);
  assign vs.vblnk  = (vc >= 11'd4);
  assign vs.hcount = hc;
  assign vs.hsync  = (hc == 11'd7);
  assign vs.hblnk  = (hc >= 11'd6);
  assign vs.rgb    = {4'h1, vc[3:0], hc[3:0]};

  assign vg.vcount = vc;
  assign vg.vsync  = (vc == 11'd5);
  assign vg.vblnk  = (vc >= 11'd4);
  assign vg.hcount = hc;
  assign vg.hsync  = (hc == 11'd7);
  assign vg.hblnk  = (hc >= 11'd6);
  assign vg.rgb    = {4'h2, vc[3:0], hc[3:0]};

  assign vf.vcount = vc;
  assign vf.vsync  = (vc == 11'd5);
  assign vf.vblnk  = (vc >= 11'd4);
  assign vf.hcount = hc;
  assign vf.hsync  = (hc == 11'd7);
  assign vf.hblnk  = (hc >= 11'd6);
  assign vf.rgb    = {4'h3, vc[3:0], hc[3:0]};

  wire [37:0] out_bus = {vo.vcount, vo.vsync, vo.vblnk,
                         vo.hcount, vo.hsync, vo.hblnk, vo.rgb};
  wire [37:0] st_bus  = {vs.vcount, vs.vsync, vs.vblnk,
                         vs.hcount, vs.hsync, vs.hblnk, vs.rgb};

  logic vb_d = 1'b0;
  always @(posedge clk) vb_d <= rst ? 1'b0 : vs.vblnk;
  wire fb_tb = vs.vblnk & ~vb_d;

  always @(posedge clk) if (game_rst === 1'b1) grst_cnt <= grst_cnt + 1;

  screen_ctrl #(
    .MIN_FINISH_FRAMES    (3),
    .FINISH_TIMEOUT_FRAMES(5),
    .CNT_W                (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_start  (btn_start),
    .game_over  (game_over),
    .vga_start  (vs),
    .vga_game   (vg),
    .vga_finish (vf),
    .vga_out    (vo),
    .screen     (screen),
    .game_active(game_active),
    .game_rst   (game_rst)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fb();
    int k;
    k = 0;
    step();
    while (!fb_tb && k < 200) begin
      step();
      k++;
    end
    chk("fb_seen", fb_tb, 1);
  endtask

  task automatic press();
    btn_start = 1'b1;
    step(4);
    btn_start = 1'b0;
    step();
  endtask

  task automatic pulse_go();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset with live source data
    rst = 1'b1;
    step(5);
    chk("rst_out", out_bus, 0);
    chk("rst_scr", screen, 0);
    chk("rst_act", game_active, 0);
    chk("rst_grst", game_rst, 0);
    exp_bus = st_bus;
    rst = 1'b0;
    step();
    chk("rel_mux", out_bus, exp_bus);

    // game_over in START is ignored
    g0 = grst_cnt;
    wait_fb();
    step(20);
    pulse_go();
    wait_fb();
    step();
    chk("go_start_scr", screen, 0);
    chk("go_start_grst", grst_cnt - g0, 0);

    // start mid-frame
    wait_fb();
    step(20);
    press();
    g0 = grst_cnt;
    wait_fb();
    chk("commit_grst", game_rst, 1);
    chk("commit_scr", screen, 0);
    step();
    chk("play_scr", screen, 1);
    chk("play_act", game_active, 1);
    chk("play_grst_off", game_rst, 0);
    erg = vg.rgb;
    step();
    chk("play_rgb", vo.rgb, erg);
    chk("grst_once", grst_cnt - g0, 1);

    // btn in PLAY is ignored
    g0 = grst_cnt;
    step(20);
    press();
    wait_fb();
    wait_fb();
    step();
    chk("btn_play_scr", screen, 1);
    chk("btn_play_grst", grst_cnt - g0, 0);

    // game_over coincident with fb waits one more frame
    wait_fb();
    pulse_go();
    step(5);
    chk("coin_hold", screen, 1);
    wait_fb();
    chk("coin_fb_scr", screen, 1);
    step();
    chk("coin_fin", screen, 2);
    erg = vf.rgb;
    step();
    chk("fin_rgb", vo.rgb, erg);

    // finish lockout (min 3 frames)
    wait_fb();
    step(20);
    press();
    wait_fb();
    step();
    chk("lock_scr", screen, 2);
    wait_fb();
    step(20);
    press();
    wait_fb();
    chk("unlock_fb_scr", screen, 2);
    step();
    chk("unlock_scr", screen, 0);
    erg = vs.rgb;
    step();
    chk("start_rgb", vo.rgb, erg);

    // back to PLAY, then FINISH with no button
    wait_fb();
    step(20);
    press();
    wait_fb();
    step();
    chk("play2_scr", screen, 1);
    step(20);
    pulse_go();
    wait_fb();
    step();
    chk("fin2_scr", screen, 2);

`ifdef SCREEN_CTRL_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      wait_fb();
      step();
      chk($sformatf("to_hold%0d", k), screen, 2);
    end
    wait_fb();
    step();
    chk("to_exit", screen, 0);
`else
    repeat (20) wait_fb();
    step();
    chk("no_to", screen, 2);
    erg = vf.rgb;
    step();
    chk("no_to_rgb", vo.rgb, erg);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
